immediate_extender_pipe: RTL and testbench
==========================================

Name: immediate_extender_pipe

Overview:
- Parametrised, registered successor to the decode-stage immediate extender.
- Extends LANES instructions per cycle to XLEN bits: covers the I/S/B/U/J types plus the CSR zimm (Z) type, and flags illegal selectors.
- Sits between instruction decode and the ID/EX boundary.
- Uses a valid/ready handshake with a 2-entry skid buffer, a flush input, and a delivered-immediate counter.

Parameters:
- XLEN, 32, output width; legal values are 32 or 64 (elaboration error otherwise).
- LANES, 1, instructions per bundle; legal range 1..4 (elaboration error otherwise).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- Flush  in  1  discard all buffered bundles.
- In_Valid  in  1  input bundle valid.
- In_Ready  out  1  block can accept a bundle this cycle.
- In_Mask  in  LANES  per-lane valid.
- Instr  in  LANES x 32  instruction words.
- Imm_Type_Sel  in  LANES x 3  immediate type per lane.
- Out_Valid  out  1  output bundle valid.
- Out_Ready  in  1  consumer accepts the bundle.
- Out_Mask  out  LANES  registered copy of In_Mask.
- Imm_Ext  out  LANES x XLEN  extended immediates.
- Imm_Illegal  out  LANES  selector 6 or 7 on an active lane.
- Ext_Count  out  32  count of active lanes delivered.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset values: Out_Valid=0, Out_Mask=0, Imm_Ext=0, Imm_Illegal=0, Ext_Count=0, skid empty.
- In_Ready: In_Ready = !skid_valid && !RST. It is derived from registers only, with no combinational path from Out_Ready.
- Handshakes: accept = In_Valid && In_Ready; deliver = Out_Valid && Out_Ready.
- Latency: 1 cycle from accept to Out_Valid when the output stage is empty or draining. Full throughput of 1 bundle/cycle while Out_Ready=1.
- Extension per active lane (sign bit s = Instr[31]; all fields sign-extended to XLEN):
  - I: Instr[31:20].
  - S: {Instr[31:25], Instr[11:7]}.
  - B: {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
  - U: {Instr[31:12], 12'b0}; for XLEN=64, bits 63:32 = s.
  - J: {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
  - Z: zero-extend Instr[19:15].
  - Selector 6/7: Imm_Ext=0, Imm_Illegal=1.
  - Inactive lane (mask bit 0): Imm_Ext=0, Imm_Illegal=0.
- Extension is computed combinationally at the input, and the result is stored in the registers.
- Buffer state machine (output register + skid register):
  - EMPTY: on accept, go to ONE (output register loaded).
  - ONE:
    - accept && !deliver: go to FULL (new bundle into skid).
    - accept && deliver: stay in ONE (output register reloaded with new bundle).
    - !accept && deliver: go to EMPTY.
    - Otherwise hold.
  - FULL: In_Ready=0. On deliver, go to ONE (skid moves to output, skid cleared).
- Ordering: bundles leave strictly in accept order. Output data is held stable while Out_Valid && !Out_Ready.
- Flush: takes priority over accept and deliver.
  - Next state is EMPTY: Out_Valid=0, skid empty, Out_Mask=0.
  - A bundle presented in the Flush cycle is dropped.
  - A deliver in the Flush cycle still counts.
- Ext_Count: on deliver, += popcount(Out_Mask). Wraps modulo 2^32. Unaffected by Flush. Cleared only by RST.
- Reset mid-operation: all buffered bundles are discarded and outputs return to their reset values on the next edge.

Decomposition:
- In the definitions package:
  - imm_type_t enum: IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4, IMM_Z=5 (new).
  - Constant IMM_SEL_W=3.
  - Existing CLOCK_PERIOD for the bench.
- One sub-module, imm_lane_extend: a combinational single-lane extender parametrised by XLEN, with outputs imm and illegal. It is instantiated LANES times in a generate loop.
- The buffer state machine, skid register and counter stay in the top module.

Test Plan:
1. XLEN=32, LANES=1, Out_Ready=1, Instr=0x2A2A2A2A:
   - sel I -> Imm_Ext=0x000002A2 one cycle after accept.
   - sel B -> Imm_Ext=0x000002B4.
   - Ext_Count=2.
2. XLEN=64:
   - U, Instr=0x80000037 -> Imm_Ext=0xFFFFFFFF80000000.
   - Z, Instr=0x000FD073 -> 0x000000000000001F.
   - I, Instr=0xFFF00013 -> 0xFFFFFFFFFFFFFFFF.
3. Backpressure: Out_Ready=0, send bundles A, B, C back-to-back:
   - A is held on the output; In_Ready=0 after B is accepted; C stalls.
   - Raise Out_Ready: delivery order is A, B, C, one per cycle, with no loss or duplication.
4. Flush while FULL (Out_Ready=0), with In_Valid=1 in the same cycle:
   - Next cycle: Out_Valid=0, In_Ready=1, Ext_Count unchanged.
   - The flushed-cycle bundle is never output.
5. LANES=2:
   - In_Mask=2'b01, sels {6, I} -> lane1 Imm_Ext=0, Imm_Illegal=0; lane0 extends correctly; Ext_Count+=1.
   - In_Mask=2'b11 with sel 7 on lane1 -> lane1 Imm_Ext=0, Imm_Illegal[1]=1.
6. Random regression: 1000 bundles per type with random Out_Ready and random RST pulses. A scoreboard checks every delivered lane against the reference formulas, the order, and Ext_Count modulo 2^32.

Source files
------------

// File: rtl/immediate_extender_pipe_pkg.sv
// Shared definitions for the pipelined immediate extender: selector
// encodings, buffer state encoding and a lane-mask population count.
package immediate_extender_pipe_pkg;

    localparam int IMM_SEL_W    = 3;
    localparam int CLOCK_PERIOD = 10;

    // Immediate format selector; codes 6 and 7 are reserved (illegal).
    typedef enum logic [IMM_SEL_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_type_t;

    // Bit 0 = output register holds a bundle, bit 1 = skid register holds one.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b11
    } buf_state_t;

    // Number of set bits in a lane mask of up to four lanes.
    function automatic logic [31:0] mask_popcount(input logic [3:0] mask);
        logic [31:0] total;
        total = 32'd0;
        for (int i = 0; i < 4; i++) begin
            total = total + {31'd0, mask[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/immediate_extender_pipe_lane.sv
// Combinational single-lane immediate extender. Reserved selectors raise
// 'illegal' with a zero immediate; an inactive lane produces all zeros.
module imm_lane_extend
    import immediate_extender_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          instr,
    input  logic [IMM_SEL_W-1:0] sel,
    input  logic                 active,
    output logic [XLEN-1:0]      imm,
    output logic                 illegal
);

    // 32-bit immediate already sign-extended; Z leaves bit 31 clear so the
    // common sign extension below also zero-extends it correctly.
    logic [31:0] field_s;
    logic        legal_s;

    // Assemble the 32-bit immediate for the selected format
    always_comb begin
        field_s = 32'd0;
        legal_s = 1'b1;
        case (imm_type_t'(sel))
            IMM_I:   field_s = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   field_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   field_s = {{19{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            IMM_U:   field_s = {instr[31:12], 12'd0};
            IMM_J:   field_s = {{11{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0};
            IMM_Z:   field_s = {27'd0, instr[19:15]};
            default: legal_s = 1'b0;
        endcase
    end

    // Widen to XLEN and gate inactive or reserved-selector lanes to zero
    always_comb begin
        imm     = {XLEN{1'b0}};
        illegal = 1'b0;
        if (!active) begin
            imm     = {XLEN{1'b0}};
            illegal = 1'b0;
        end else if (!legal_s) begin
            imm     = {XLEN{1'b0}};
            illegal = 1'b1;
        end else begin
            imm     = XLEN'($signed(field_s));
            illegal = 1'b0;
        end
    end

endmodule

// File: rtl/immediate_extender_pipe.sv
// Registered multi-lane immediate extender between decode and ID/EX.
// Extension happens at the input; results sit in an output register backed
// by a one-entry skid register so In_Ready depends only on flops and RST.
module immediate_extender_pipe
    import immediate_extender_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LANES = 1
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              Flush,
    input  logic                              In_Valid,
    output logic                              In_Ready,
    input  logic [LANES-1:0]                  In_Mask,
    input  logic [LANES-1:0][31:0]            Instr,
    input  logic [LANES-1:0][IMM_SEL_W-1:0]   Imm_Type_Sel,
    output logic                              Out_Valid,
    input  logic                              Out_Ready,
    output logic [LANES-1:0]                  Out_Mask,
    output logic [LANES-1:0][XLEN-1:0]        Imm_Ext,
    output logic [LANES-1:0]                  Imm_Illegal,
    output logic [31:0]                       Ext_Count
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("immediate_extender_pipe: XLEN must be 32 or 64");
    end
    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $error("immediate_extender_pipe: LANES must be within 1..4");
    end

    buf_state_t                 state_r;
    buf_state_t                 state_nxt_s;
    logic                       accept_s;
    logic                       deliver_s;
    logic                       skid_valid_s;
    logic                       load_out_in_s;
    logic                       load_out_skid_s;
    logic                       load_skid_s;

    logic [XLEN-1:0]            ext_imm_s [LANES];
    logic                       ext_ill_s [LANES];
    logic [LANES-1:0][XLEN-1:0] ext_imm_pk_s;
    logic [LANES-1:0]           ext_ill_pk_s;

    logic [LANES-1:0]           out_mask_r;
    logic [LANES-1:0][XLEN-1:0] out_imm_r;
    logic [LANES-1:0]           out_ill_r;
    logic [LANES-1:0]           skid_mask_r;
    logic [LANES-1:0][XLEN-1:0] skid_imm_r;
    logic [LANES-1:0]           skid_ill_r;
    logic [31:0]                count_r;
    logic [3:0]                 out_mask_pad_s;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        imm_lane_extend #(
            .XLEN (XLEN)
        ) u_ext (
            .instr   (Instr[g]),
            .sel     (Imm_Type_Sel[g]),
            .active  (In_Mask[g]),
            .imm     (ext_imm_s[g]),
            .illegal (ext_ill_s[g])
        );
    end

    // Gather per-lane extender results into packed bundles
    always_comb begin
        ext_imm_pk_s = {(LANES*XLEN){1'b0}};
        ext_ill_pk_s = {LANES{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            ext_imm_pk_s[l] = ext_imm_s[l];
            ext_ill_pk_s[l] = ext_ill_s[l];
        end
    end

    assign skid_valid_s   = state_r[1];
    assign Out_Valid      = state_r[0];
    assign In_Ready       = !skid_valid_s && !RST;
    assign accept_s       = In_Valid && In_Ready;
    assign deliver_s      = Out_Valid && Out_Ready;
    assign out_mask_pad_s = 4'(out_mask_r);

    // Next buffer state and which register loads; Flush overrides everything
    always_comb begin
        state_nxt_s     = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        if (Flush) begin
            state_nxt_s = BUF_EMPTY;
        end else begin
            case (state_r)
                BUF_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s   = BUF_ONE;
                        load_out_in_s = 1'b1;
                    end else begin
                        state_nxt_s   = BUF_EMPTY;
                    end
                end
                BUF_ONE: begin
                    if (accept_s && !deliver_s) begin
                        state_nxt_s   = BUF_FULL;
                        load_skid_s   = 1'b1;
                    end else if (accept_s && deliver_s) begin
                        state_nxt_s   = BUF_ONE;
                        load_out_in_s = 1'b1;
                    end else if (deliver_s) begin
                        state_nxt_s   = BUF_EMPTY;
                    end else begin
                        state_nxt_s   = BUF_ONE;
                    end
                end
                BUF_FULL: begin
                    if (deliver_s) begin
                        state_nxt_s     = BUF_ONE;
                        load_out_skid_s = 1'b1;
                    end else begin
                        state_nxt_s     = BUF_FULL;
                    end
                end
                default: begin
                    state_nxt_s = BUF_EMPTY;
                end
            endcase
        end
    end

    // Buffer state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= BUF_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output register: loads from the extenders or from the skid entry
    always_ff @(posedge CLK) begin
        if (RST || Flush) begin
            out_mask_r <= {LANES{1'b0}};
            out_imm_r  <= {(LANES*XLEN){1'b0}};
            out_ill_r  <= {LANES{1'b0}};
        end else if (load_out_in_s) begin
            out_mask_r <= In_Mask;
            out_imm_r  <= ext_imm_pk_s;
            out_ill_r  <= ext_ill_pk_s;
        end else if (load_out_skid_s) begin
            out_mask_r <= skid_mask_r;
            out_imm_r  <= skid_imm_r;
            out_ill_r  <= skid_ill_r;
        end else begin
            out_mask_r <= out_mask_r;
            out_imm_r  <= out_imm_r;
            out_ill_r  <= out_ill_r;
        end
    end

    // Skid register: captures a bundle accepted while the output is stalled
    always_ff @(posedge CLK) begin
        if (RST || Flush || load_out_skid_s) begin
            skid_mask_r <= {LANES{1'b0}};
            skid_imm_r  <= {(LANES*XLEN){1'b0}};
            skid_ill_r  <= {LANES{1'b0}};
        end else if (load_skid_s) begin
            skid_mask_r <= In_Mask;
            skid_imm_r  <= ext_imm_pk_s;
            skid_ill_r  <= ext_ill_pk_s;
        end else begin
            skid_mask_r <= skid_mask_r;
            skid_imm_r  <= skid_imm_r;
            skid_ill_r  <= skid_ill_r;
        end
    end

    // Delivered-lane counter; a deliver in a Flush cycle still counts
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_r <= 32'd0;
        end else if (deliver_s) begin
            count_r <= count_r + mask_popcount(out_mask_pad_s);
        end else begin
            count_r <= count_r;
        end
    end

    assign Out_Mask    = out_mask_r;
    assign Imm_Ext     = out_imm_r;
    assign Imm_Illegal = out_ill_r;
    assign Ext_Count   = count_r;

endmodule

// File: tb/tb_immediate_extender_pipe.sv
// Self-checking bench: a 64-bit two-lane instance and a 32-bit single-lane
// instance share stimulus (the narrow one sees lane 0). A queue-based model
// predicts handshakes, data and counts; directed tables and sequences pin
// down exact values.
module tb_immediate_extender_pipe;
    import immediate_extender_pipe_pkg::*;

    logic clk = 1'b0;
    always #(CLOCK_PERIOD/2) clk = ~clk;

    logic            rst, flush, in_valid, out_ready;
    logic [1:0]      in_mask;
    logic [1:0][31:0] instr;
    logic [1:0][2:0] sel;

    logic             rdy64, ov64;
    logic [1:0]       om64, ill64;
    logic [1:0][63:0] imm64;
    logic [31:0]      cnt64;

    logic             rdy32, ov32;
    logic [0:0]       om32, ill32;
    logic [0:0][31:0] imm32;
    logic [31:0]      cnt32;

    immediate_extender_pipe #(.XLEN(64), .LANES(2)) dut64 (
        .CLK(clk), .RST(rst), .Flush(flush), .In_Valid(in_valid), .In_Ready(rdy64),
        .In_Mask(in_mask), .Instr(instr), .Imm_Type_Sel(sel), .Out_Valid(ov64),
        .Out_Ready(out_ready), .Out_Mask(om64), .Imm_Ext(imm64), .Imm_Illegal(ill64),
        .Ext_Count(cnt64));

    immediate_extender_pipe #(.XLEN(32), .LANES(1)) dut32 (
        .CLK(clk), .RST(rst), .Flush(flush), .In_Valid(in_valid), .In_Ready(rdy32),
        .In_Mask(in_mask[0]), .Instr(instr[0]), .Imm_Type_Sel(sel[0]), .Out_Valid(ov32),
        .Out_Ready(out_ready), .Out_Mask(om32), .Imm_Ext(imm32), .Imm_Illegal(ill32),
        .Ext_Count(cnt32));

    typedef struct {
        logic [1:0]       mask;
        logic [1:0][31:0] w;
        logic [1:0][2:0]  t;
    } bundle_t;

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] w0; logic [2:0] t0;
        logic [31:0] w1; logic [2:0] t1;
        logic [63:0] e0; logic [63:0] e1;
        logic [1:0]  eill;
        logic [31:0] e32;
        logic [31:0] ecnt;
    } vec_t;

    int tests = 0;
    int fails = 0;
    bundle_t q[$];
    logic [31:0] mcnt64, mcnt32;
    bit zero_all, zero_mask;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value-level reference: field bits interpreted as a signed number.
    function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] t,
                                            input logic act, input int xlen);
        longint v;
        if (!act || t > 3'd5) return 64'd0;
        case (t)
            3'd0:    v = longint'($signed(w[31:20]));
            3'd1:    v = longint'($signed({w[31:25], w[11:7]}));
            3'd2:    v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            3'd3:    v = longint'($signed({w[31:12], 12'h000}));
            3'd4:    v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: v = longint'(w[19:15]);
        endcase
        if (xlen == 32) return {32'd0, v[31:0]};
        return v;
    endfunction

    function automatic logic ref_ill(input logic [2:0] t, input logic act);
        return act && (t >= 3'd6);
    endfunction

    task automatic check_outputs();
        logic exp_rdy;
        exp_rdy = !rst && (q.size() < 2);
        chk("in_ready_x64", rdy64, exp_rdy);
        chk("in_ready_x32", rdy32, exp_rdy);
        chk("out_valid_x64", ov64, q.size() > 0);
        chk("out_valid_x32", ov32, q.size() > 0);
        if (q.size() > 0) begin
            for (int l = 0; l < 2; l++) begin
                chk("imm_x64", imm64[l], ref_imm(q[0].w[l], q[0].t[l], q[0].mask[l], 64));
                chk("illegal_x64", ill64[l], ref_ill(q[0].t[l], q[0].mask[l]));
            end
            chk("mask_x64", om64, q[0].mask);
            chk("mask_x32", om32, q[0].mask[0]);
            chk("imm_x32", imm32[0], ref_imm(q[0].w[0], q[0].t[0], q[0].mask[0], 32));
            chk("illegal_x32", ill32, ref_ill(q[0].t[0], q[0].mask[0]));
        end else begin
            if (zero_mask) begin
                chk("idle_mask_x64", om64, 64'd0);
                chk("idle_mask_x32", om32, 64'd0);
            end
            if (zero_all) begin
                chk("idle_imm_x64", imm64[0] | imm64[1], 64'd0);
                chk("idle_ill_x64", ill64, 64'd0);
                chk("idle_imm_x32", imm32[0], 64'd0);
            end
        end
        chk("ext_count_x64", cnt64, mcnt64);
        chk("ext_count_x32", cnt32, mcnt32);
    endtask

    // One clock: check at negedge, advance model at posedge, return at +1.
    task automatic tick();
        bundle_t cur;
        bit acc, dlv;
        @(negedge clk);
        check_outputs();
        cur.mask = in_mask;
        cur.w    = instr;
        cur.t    = sel;
        acc = in_valid && !rst && (q.size() < 2);
        dlv = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            q.delete();
            mcnt64 = 32'd0; mcnt32 = 32'd0;
            zero_all = 1'b1; zero_mask = 1'b1;
        end else begin
            if (dlv) begin
                mcnt64 = mcnt64 + 32'($countones(q[0].mask));
                mcnt32 = mcnt32 + {31'd0, q[0].mask[0]};
            end
            if (flush) begin
                q.delete();
                zero_mask = 1'b1; zero_all = 1'b0;
            end else begin
                if (dlv) void'(q.pop_front());
                if (acc) begin
                    q.push_back(cur);
                    zero_mask = 1'b0; zero_all = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] w0,
                         input logic [2:0] t0, input logic [31:0] w1, input logic [2:0] t1);
        in_valid = v; in_mask = m;
        instr[0] = w0; sel[0] = t0; instr[1] = w1; sel[1] = t1;
    endtask

    vec_t tbl[11];
    logic [31:0] cnt_before;

    initial begin
        tbl[0]  = '{2'b01, 32'h2A2A2A2A, 3'd0, 32'h0,        3'd0, 64'h2A2, 64'h0, 2'b00, 32'h2A2, 32'd1};
        tbl[1]  = '{2'b01, 32'h2A2A2A2A, 3'd2, 32'h0,        3'd0, 64'h2B4, 64'h0, 2'b00, 32'h2B4, 32'd1};
        tbl[2]  = '{2'b01, 32'h80000037, 3'd3, 32'h0,        3'd0, 64'hFFFFFFFF80000000, 64'h0, 2'b00, 32'h80000000, 32'd1};
        tbl[3]  = '{2'b01, 32'h000FD073, 3'd5, 32'h0,        3'd0, 64'h1F, 64'h0, 2'b00, 32'h1F, 32'd1};
        tbl[4]  = '{2'b01, 32'hFFF00013, 3'd0, 32'h0,        3'd0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 2'b00, 32'hFFFFFFFF, 32'd1};
        tbl[5]  = '{2'b01, 32'h2A2A2A2A, 3'd0, 32'hFFFFFFFF, 3'd6, 64'h2A2, 64'h0, 2'b00, 32'h2A2, 32'd1};
        tbl[6]  = '{2'b11, 32'hFE0000A3, 3'd1, 32'h12345678, 3'd7, 64'hFFFFFFFFFFFFFFE1, 64'h0, 2'b10, 32'hFFFFFFE1, 32'd2};
        tbl[7]  = '{2'b11, 32'h8000006F, 3'd4, 32'h0010006F, 3'd4, 64'hFFFFFFFFFFF00000, 64'h800, 2'b00, 32'hFFF00000, 32'd2};
        tbl[8]  = '{2'b11, 32'h12345037, 3'd3, 32'hFFFFFFFF, 3'd5, 64'h12345000, 64'h1F, 2'b00, 32'h12345000, 32'd2};
        tbl[9]  = '{2'b11, 32'h80000063, 3'd2, 32'h0,        3'd6, 64'hFFFFFFFFFFFFF000, 64'h0, 2'b10, 32'hFFFFF000, 32'd2};
        tbl[10] = '{2'b11, 32'hFFFFFFFF, 3'd7, 32'h00100013, 3'd0, 64'h0, 64'h1, 2'b01, 32'h0, 32'd2};

        // Reset: registers are unknown until the first edges complete.
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 3'd0, 32'h0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        q.delete(); mcnt64 = 32'd0; mcnt32 = 32'd0; zero_all = 1'b1; zero_mask = 1'b1;
        chk("reset_out_valid", ov64, 64'd0);
        chk("reset_out_mask", om64, 64'd0);
        chk("reset_imm_lane0", imm64[0], 64'd0);
        chk("reset_illegal", ill64, 64'd0);
        chk("reset_ext_count", cnt64, 64'd0);
        chk("reset_in_ready", rdy64, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Directed extension vectors, one bundle at a time with Out_Ready=1.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cnt_before = cnt64;
            drive(1'b1, tbl[i].mask, tbl[i].w0, tbl[i].t0, tbl[i].w1, tbl[i].t1);
            tick();
            chk("tbl_out_valid", ov64, 64'd1);
            chk("tbl_imm_lane0", imm64[0], tbl[i].e0);
            chk("tbl_imm_lane1", imm64[1], tbl[i].e1);
            chk("tbl_illegal", ill64, tbl[i].eill);
            chk("tbl_imm_x32", imm32[0], tbl[i].e32);
            chk("tbl_illegal_x32", ill32, tbl[i].eill[0]);
            in_valid = 1'b0;
            tick();
            chk("tbl_count_delta", cnt64 - cnt_before, tbl[i].ecnt);
            if (i == 1) chk("ext_count_two_bundles_x32", cnt32, 64'd2);
        end

        // Backpressure: A held, B into skid, C stalls; then A, B, C in order.
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'h00100013, 3'd0, 32'h0, 3'd0); tick();
        chk("bp_a_held", imm64[0], 64'd1);
        drive(1'b1, 2'b01, 32'h00200013, 3'd0, 32'h0, 3'd0); tick();
        chk("bp_full_in_ready", rdy64, 64'd0);
        chk("bp_a_still", imm64[0], 64'd1);
        drive(1'b1, 2'b01, 32'h00300013, 3'd0, 32'h0, 3'd0); tick(); tick();
        chk("bp_c_stalled", imm64[0], 64'd1);
        out_ready = 1'b1; tick();
        chk("bp_order_b", imm64[0], 64'd2);
        tick();
        chk("bp_order_c", imm64[0], 64'd3);
        in_valid = 1'b0; tick();
        chk("bp_drained", ov64, 64'd0);

        // Flush while FULL with a bundle presented in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 32'h00500013, 3'd0, 32'h0, 3'd1); tick();
        drive(1'b1, 2'b11, 32'h00600013, 3'd0, 32'h0, 3'd1); tick();
        cnt_before = cnt64;
        flush = 1'b1;
        drive(1'b1, 2'b11, 32'h00700013, 3'd0, 32'h0, 3'd1); tick();
        flush = 1'b0;
        chk("flush_out_valid", ov64, 64'd0);
        chk("flush_in_ready", rdy64, 64'd1);
        chk("flush_count_kept", cnt64, cnt_before);
        chk("flush_mask_cleared", om64, 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("flush_bundle_dropped", ov64, 64'd0);

        // Random regression with random backpressure, flushes and resets.
        for (int n = 0; n < 8000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 99) == 0);
            out_ready = $urandom_range(0, 1) == 1;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                  3'($urandom_range(0, 7)), $urandom, 3'($urandom_range(0, 7)));
            tick();
        end
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
